// File: rtl/accel_stream_loader.sv
// rtl/accel_stream_loader.sv - operand FIFO and row unpacker feeding the systolic array
module accel_stream_loader #(
    parameter int Rows      = 8,
    parameter int Columns   = 8,
    parameter int Width     = 8,
    parameter int FifoDepth = 16
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       reg_we_i,
    input  logic                       reg_re_i,
    input  logic [1:0]                 reg_adr_i,
    input  logic [3:0]                 reg_sel_i,
    input  logic [31:0]                reg_dat_i,
    output logic [31:0]                reg_dat_o,
    output logic                       row_valid_o,
    input  logic                       row_ready_i,
    output logic [Columns*Width-1:0]   row_data_o,
    output logic                       row_last_o,
    output logic                       irq_o
);

    localparam int RowW        = Columns * Width;
    localparam int WordsPerRow = RowW / 32;
    localparam int AW          = $clog2(FifoDepth);
    localparam int WIdxW       = (WordsPerRow > 1) ? $clog2(WordsPerRow) : 1;

    if (Rows < 1) begin : g_bad_rows
        $error("accel_stream_loader: Rows must be positive");
    end
    if ((RowW % 32) != 0 || RowW == 0) begin : g_bad_row_width
        $error("accel_stream_loader: Columns*Width must be a non-zero multiple of 32");
    end
    if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
        $error("accel_stream_loader: FifoDepth must be a power of 2, at least 2");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATHER = 2'd1,
        SEND   = 2'd2
    } state_t;

    state_t             state;
    logic [31:0]        fifo_mem [FifoDepth];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [AW:0]        level;
    logic               full;
    logic               empty;
    logic [15:0]        len_q;
    logic [15:0]        row_cnt;
    logic [WIdxW-1:0]   word_idx;
    logic               done;
    logic               overflow;
    logic [RowW-1:0]    row_data_q;

    logic               ctrl_wr;
    logic               clear;
    logic               start;
    logic               data_wr;
    logic               pop;
    logic               push;
    logic [31:0]        data_masked;
    logic [31:0]        fifo_head;
    logic [31:0]        rd_mux;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign level     = wr_ptr - rd_ptr;
    assign full      = (level == (AW+1)'(FifoDepth));
    assign empty     = (level == '0);
    assign fifo_head = fifo_mem[rd_ptr[AW-1:0]];

    assign ctrl_wr = reg_we_i && (reg_adr_i == 2'd0);
    assign clear   = ctrl_wr && reg_dat_i[1];
    assign start   = ctrl_wr && reg_dat_i[0] && !reg_dat_i[1];
    assign data_wr = reg_we_i && (reg_adr_i == 2'd3);
    assign pop     = (state == GATHER) && !empty && !clear;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push    = data_wr && (!full || pop);

    always_comb begin
        data_masked = '0;
        for (int b = 0; b < 4; b++) begin
            if (reg_sel_i[b]) begin
                data_masked[8*b +: 8] = reg_dat_i[8*b +: 8];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_adr_i)
            2'd1:    rd_mux = {16'h0000, 8'(level), 3'b000, overflow, empty, full, done,
                               (state != IDLE)};
            2'd2:    rd_mux = {16'h0000, len_q};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= data_masked;
        end
    end

    assign row_data_o = row_data_q;
    assign irq_o      = done;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            len_q       <= '0;
            row_cnt     <= '0;
            word_idx    <= '0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            row_data_q  <= '0;
            row_valid_o <= 1'b0;
            row_last_o  <= 1'b0;
            reg_dat_o   <= '0;
        end else begin
            if (reg_re_i) begin
                reg_dat_o <= rd_mux;
            end

            if (reg_we_i && (reg_adr_i == 2'd2) && (state == IDLE)) begin
                if (reg_sel_i[0]) len_q[7:0]  <= reg_dat_i[7:0];
                if (reg_sel_i[1]) len_q[15:8] <= reg_dat_i[15:8];
            end

            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end

            if (data_wr && full && !pop) begin
                overflow <= 1'b1;
            end

            if (clear) begin
                state       <= IDLE;
                done        <= 1'b0;
                overflow    <= 1'b0;
                word_idx    <= '0;
                row_valid_o <= 1'b0;
                row_last_o  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (len_q != 16'd0) begin
                                state    <= GATHER;
                                row_cnt  <= '0;
                                word_idx <= '0;
                                done     <= 1'b0;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    GATHER: begin
                        if (pop) begin
                            row_data_q[{word_idx, 5'd0} +: 32] <= fifo_head;
                            if (word_idx == WIdxW'(WordsPerRow - 1)) begin
                                word_idx    <= '0;
                                state       <= SEND;
                                row_valid_o <= 1'b1;
                                row_last_o  <= (row_cnt == len_q - 16'd1);
                            end else begin
                                word_idx <= word_idx + 1'b1;
                            end
                        end
                    end
                    SEND: begin
                        if (row_ready_i) begin
                            row_valid_o <= 1'b0;
                            row_last_o  <= 1'b0;
                            row_cnt     <= row_cnt + 16'd1;
                            if (row_last_o) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end else begin
                                state <= GATHER;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_accel_stream_loader.sv
// tb/tb_accel_stream_loader.sv - directed bench with queue-based row scoreboard
module tb_accel_stream_loader;

    localparam int Columns   = 8;
    localparam int Width     = 8;
    localparam int FifoDepth = 16;
    localparam int RW        = Columns * Width;
    localparam int WPR       = RW / 32;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i = 1'b0;
    logic          reg_we_i = 1'b0;
    logic          reg_re_i = 1'b0;
    logic [1:0]    reg_adr_i = '0;
    logic [3:0]    reg_sel_i = '0;
    logic [31:0]   reg_dat_i = '0;
    logic [31:0]   reg_dat_o;
    logic          row_valid_o;
    logic          row_ready_i = 1'b0;
    logic [RW-1:0] row_data_o;
    logic          row_last_o;
    logic          irq_o;

    accel_stream_loader #(
        .Rows(8), .Columns(Columns), .Width(Width), .FifoDepth(FifoDepth)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .reg_we_i(reg_we_i), .reg_re_i(reg_re_i), .reg_adr_i(reg_adr_i),
        .reg_sel_i(reg_sel_i), .reg_dat_i(reg_dat_i), .reg_dat_o(reg_dat_o),
        .row_valid_o(row_valid_o), .row_ready_i(row_ready_i), .row_data_o(row_data_o),
        .row_last_o(row_last_o), .irq_o(irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_pass = 0;
    int n_chk  = 0;

    logic [31:0]   mq[$];
    bit            m_done = 0;
    bit            m_ovf  = 0;
    int            m_len  = 0;
    int            m_cnt  = 0;
    int            hs_cnt = 0;
    logic [RW-1:0] last_hs_data = '0;
    logic          last_hs_last = 1'b0;

    logic          prev_stall = 1'b0;
    logic          prev_clear = 1'b0;
    logic [RW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    function automatic logic [31:0] exp_status(input bit busy);
        int lvl;
        lvl = mq.size();
        return {16'h0, 8'(lvl), 3'b000, m_ovf, (lvl == 0), (lvl == FifoDepth), m_done, busy};
    endfunction

    // Scoreboard: every handshake must carry the next WPR queued words, in order.
    always @(negedge wb_clk_i) begin
        if (!wb_rst_i) begin
            prev_stall = 1'b0;
            prev_clear = 1'b0;
        end else begin
            if (prev_stall && !prev_clear) begin
                chk("stall_valid", row_valid_o, 1'b1);
                chk("stall_data", row_data_o, prev_data);
                chk("stall_last", row_last_o, prev_last);
            end
            if (row_valid_o && row_ready_i) begin
                logic [RW-1:0] exp_row;
                logic          exp_last;
                hs_cnt++;
                last_hs_data = row_data_o;
                last_hs_last = row_last_o;
                if (mq.size() < WPR) begin
                    n_chk++;
                    $display("FAIL row_avail: got row 0x%0h expected no row", row_data_o);
                end else begin
                    exp_row = '0;
                    for (int j = 0; j < WPR; j++) exp_row[32*j +: 32] = mq.pop_front();
                    exp_last = (m_cnt == m_len - 1);
                    chk("row_data", row_data_o, exp_row);
                    chk("row_last", row_last_o, exp_last);
                    m_cnt++;
                    if (exp_last) m_done = 1;
                end
            end
            prev_stall = row_valid_o && !row_ready_i;
            prev_data  = row_data_o;
            prev_last  = row_last_o;
            prev_clear = reg_we_i && (reg_adr_i == 2'd0) && reg_dat_i[1];
        end
    end

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
        reg_we_i = 1'b1; reg_adr_i = a; reg_dat_i = d; reg_sel_i = s;
        tick();
        reg_we_i = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        reg_re_i = 1'b1; reg_adr_i = a;
        tick();
        reg_re_i = 1'b0;
        d = reg_dat_o;
    endtask

    task automatic push(input logic [31:0] w, input logic [3:0] s);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = w[8*b +: 8];
        wr(2'd3, w, s);
        if (mq.size() < FifoDepth) mq.push_back(m);
        else m_ovf = 1;
    endtask

    task automatic set_len(input int v);
        wr(2'd2, 32'(v), 4'hF);
        m_len = v;
    endtask

    task automatic start_job();
        wr(2'd0, 32'h1, 4'hF);
        if (m_len != 0) begin m_cnt = 0; m_done = 0; end
        else m_done = 1;
    endtask

    task automatic ctrl_clear(input logic [31:0] v);
        wr(2'd0, v, 4'hF);
        mq.delete();
        m_done = 0;
        m_ovf  = 0;
    endtask

    task automatic wait_idle(input string name);
        logic [31:0] s;
        s = 32'h1;
        for (int i = 0; i < 200; i++) begin
            rd(2'd1, s);
            if (!s[0]) break;
        end
        chk(name, s[0], 1'b0);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 50; i++) begin
            if (row_valid_o) break;
            tick();
        end
        chk(name, row_valid_o, 1'b1);
    endtask

    initial begin
        logic [31:0] s;
        repeat (3) tick();
        wb_rst_i = 1'b1;
        tick();

        rd(2'd1, s);
        chk("reset_status", s, 32'h0000_0008);
        chk("reset_status_model", s, exp_status(0));
        chk("reset_valid", row_valid_o, 1'b0);
        chk("reset_irq", irq_o, 1'b0);
        chk("reset_data", row_data_o, 64'h0);

        // Single-row job.
        set_len(1);
        push(32'h0403_0201, 4'hF);
        push(32'h0807_0605, 4'hF);
        row_ready_i = 1'b1;
        start_job();
        wait_idle("t1_idle");
        chk("t1_hs", hs_cnt, 1);
        chk("t1_row", last_hs_data, 64'h0807_0605_0403_0201);
        chk("t1_last", last_hs_last, 1'b1);
        rd(2'd1, s);
        chk("t1_status", s, 32'h0000_000A);
        chk("t1_irq", irq_o, 1'b1);

        // Two rows with backpressure on the first.
        row_ready_i = 1'b0;
        set_len(2);
        push(32'h1111_1111, 4'hF);
        push(32'h2222_2222, 4'hF);
        push(32'h3333_3333, 4'hF);
        push(32'h4444_4444, 4'hF);
        start_job();
        wait_valid("t2_valid");
        repeat (5) tick();
        chk("t2_held_valid", row_valid_o, 1'b1);
        chk("t2_no_hs", hs_cnt, 1);
        row_ready_i = 1'b1;
        wait_idle("t2_idle");
        chk("t2_hs", hs_cnt, 3);
        chk("t2_row2", last_hs_data, 64'h4444_4444_3333_3333);
        chk("t2_last", last_hs_last, 1'b1);

        // Overfill with no job running, then drain through an 8-row job.
        row_ready_i = 1'b0;
        for (int i = 0; i < 17; i++) push(32'hA000_0000 + 32'(i), 4'hF);
        rd(2'd1, s);
        chk("t3_full_status", s, 32'h0000_1016);
        chk("t3_full_model", s, exp_status(0));
        set_len(8);
        row_ready_i = 1'b1;
        start_job();
        wr(2'd2, 32'h5, 4'hF);
        rd(2'd2, s);
        chk("t3_len_locked", s, 32'h8);
        wait_idle("t3_idle");
        chk("t3_hs", hs_cnt, 11);
        chk("t3_final_row", last_hs_data, 64'hA000_000F_A000_000E);
        rd(2'd1, s);
        chk("t3_status", s, 32'h0000_001A);

        // Clear, byte-masked LEN write, and a job that stalls for data.
        ctrl_clear(32'h2);
        rd(2'd1, s);
        chk("t4_clear_status", s, 32'h0000_0008);
        wr(2'd2, 32'h00AB_0003, 4'b0001);
        m_len = 3;
        rd(2'd2, s);
        chk("t4_len_masked", s, 32'h3);
        push(32'hC1C1_C1C1, 4'hF);
        push(32'hC2C2_C2C2, 4'hF);
        push(32'hDDCC_BBAA, 4'b0101);
        start_job();
        for (int i = 0; i < 50 && hs_cnt < 12; i++) tick();
        repeat (4) tick();
        chk("t4_stall_hs", hs_cnt, 12);
        rd(2'd1, s);
        chk("t4_stall_status", s, 32'h0000_0009);
        push(32'hC4C4_C4C4, 4'hF);
        push(32'hC5C5_C5C5, 4'hF);
        push(32'hC6C6_C6C6, 4'hF);
        wait_idle("t4_idle");
        chk("t4_hs", hs_cnt, 14);
        chk("t4_final_row", last_hs_data, 64'hC6C6_C6C6_C5C5_C5C5);
        rd(2'd1, s);
        chk("t4_status", s, 32'h0000_000A);

        // Clear+start mid-job, then a zero-length start.
        row_ready_i = 1'b0;
        set_len(4);
        for (int i = 0; i < 4; i++) push(32'hE000_0000 + 32'(i), 4'hF);
        start_job();
        wait_valid("t5_valid");
        ctrl_clear(32'h3);
        rd(2'd1, s);
        chk("t5_clear_status", s, 32'h0000_0008);
        row_ready_i = 1'b1;
        repeat (6) tick();
        chk("t5_no_rows", hs_cnt, 14);
        chk("t5_valid_low", row_valid_o, 1'b0);
        reg_we_i = 1'b1; reg_re_i = 1'b1; reg_adr_i = 2'd2; reg_dat_i = 32'h0; reg_sel_i = 4'hF;
        tick();
        reg_we_i = 1'b0; reg_re_i = 1'b0;
        m_len = 0;
        chk("t5_rd_pre_write", reg_dat_o, 32'h4);
        rd(2'd2, s);
        chk("t5_len_zero", s, 32'h0);
        start_job();
        rd(2'd1, s);
        chk("t5_zero_len_status", s, 32'h0000_000A);
        chk("t5_zero_len_irq", irq_o, 1'b1);
        repeat (4) tick();
        chk("t5_zero_len_rows", hs_cnt, 14);
        rd(2'd0, s);
        chk("rd_ctrl_zero", s, 32'h0);
        rd(2'd3, s);
        chk("rd_data_zero", s, 32'h0);

        // Asynchronous reset while a row is waiting.
        row_ready_i = 1'b0;
        set_len(1);
        push(32'hF0F0_F0F0, 4'hF);
        push(32'h0F0F_0F0F, 4'hF);
        start_job();
        wait_valid("t6_valid");
        wb_rst_i = 1'b0;
        #1;
        chk("t6_rst_valid", row_valid_o, 1'b0);
        chk("t6_rst_irq", irq_o, 1'b0);
        mq.delete();
        m_done = 0;
        m_ovf  = 0;
        m_len  = 0;
        tick();
        wb_rst_i = 1'b1;
        tick();
        rd(2'd1, s);
        chk("t6_rst_status", s, 32'h0000_0008);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
